// File: rtl/wb_queue.sv
// wb_queue
// Writeback-side driver for the integer register file's single write port.
// Retiring results arrive from the MEM/WB boundary through a valid/ready
// handshake and wait in a small in-order circular queue. At most one entry
// per cycle goes to the register file. Two combinational bypass lookups let
// decode see values that are queued but not yet written.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   in_valid / in_ready        retiring-result handshake
//   in_we, in_addr, in_data    retiring result (write flag, destination, value)
//   hold                       write port unavailable this cycle, do not drain
//   write_enable/addr/data     register file write port
//   lookup_addr1/2             decode read addresses
//   lookup_hit1/2, data1/2     youngest queued value for each address
//   count                      number of occupied entries
module wb_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_we,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     hold,
    output logic                     write_enable,
    output logic [ADDR_W-1:0]        write_addr,
    output logic [DATA_W-1:0]        write_data,
    input  logic [ADDR_W-1:0]        lookup_addr1,
    input  logic [ADDR_W-1:0]        lookup_addr2,
    output logic                     lookup_hit1,
    output logic                     lookup_hit2,
    output logic [DATA_W-1:0]        lookup_data1,
    output logic [DATA_W-1:0]        lookup_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addrMem_q [DEPTH];
    logic [DATA_W-1:0] dataMem_q [DEPTH];
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;

    // Readiness depends only on the current occupancy, so a full queue stays
    // closed even when the head is popped in the same cycle. Results that do
    // not write a register (in_we=0 or x0) are consumed without taking a slot.
    always_comb begin
        in_ready = !rst && (count_q < DEPTH_C);
        push     = in_valid && in_ready && in_we && (in_addr != '0);
    end

    // The write port shows the head whenever something is queued and the port
    // is free. Gating with rst keeps a mid-operation reset from issuing the
    // write that the pre-reset state would otherwise present.
    always_comb begin
        write_enable = !rst && (count_q != '0) && !hold;
        write_addr   = '0;
        write_data   = '0;
        if (write_enable) begin
            write_addr = addrMem_q[rdPtr_q];
            write_data = dataMem_q[rdPtr_q];
        end
        pop = write_enable;
    end

    // Next-state for the pointers and occupancy; a simultaneous push and pop
    // moves both pointers and leaves the count unchanged.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Pointer and count registers; reset empties the queue without touching
    // the stored entries, which become unreachable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset because occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem_q[wrPtr_q] <= in_addr;
            dataMem_q[wrPtr_q] <= in_data;
        end
    end

    // Scan from oldest to youngest so the last match overwrites earlier ones,
    // leaving the youngest occupied entry as the result. The head being
    // written this cycle is still occupied and therefore still visible.
    function automatic logic [DATA_W:0] lookupEntry(input logic [ADDR_W-1:0] addr);
        logic [DATA_W:0]  result;
        logic [PTR_W-1:0] idx;
        result = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rdPtr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addrMem_q[idx] == addr)) begin
                result = {1'b1, dataMem_q[idx]};
            end
        end
        if (rst || (addr == '0)) begin
            result = '0;
        end
        return result;
    endfunction

    // Two independent bypass ports for decode.
    always_comb begin
        {lookup_hit1, lookup_data1} = lookupEntry(lookup_addr1);
        {lookup_hit2, lookup_data2} = lookupEntry(lookup_addr2);
    end

    assign count = count_q;

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue. A queue-based reference model follows
// the handshake and drain rules and is compared against every output on each
// falling edge; directed steps add hand-computed literal checks.
module tb_wb_queue;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_we;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              hold;
    logic              write_enable;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] lookup_addr1;
    logic [ADDR_W-1:0] lookup_addr2;
    logic              lookup_hit1;
    logic              lookup_hit2;
    logic [DATA_W-1:0] lookup_data1;
    logic [DATA_W-1:0] lookup_data2;
    logic [CNT_W-1:0]  count;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t modelQ[$];
    bit     modelValid = 0;

    wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_we        (in_we),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .hold         (hold),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .lookup_addr1 (lookup_addr1),
        .lookup_addr2 (lookup_addr2),
        .lookup_hit1  (lookup_hit1),
        .lookup_hit2  (lookup_hit2),
        .lookup_data1 (lookup_data1),
        .lookup_data2 (lookup_data2),
        .count        (count)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the queue holds only register-writing entries. The
    // drain decision and the ready decision both come from the occupancy
    // before the edge.
    always @(posedge clk) begin
        if (rst) begin
            modelQ.delete();
            modelValid = 1;
        end else if (modelValid) begin
            bit doPop;
            bit doPush;
            doPop  = (modelQ.size() > 0) && !hold;
            doPush = in_valid && (modelQ.size() < DEPTH) && in_we && (in_addr != 0);
            if (doPop) void'(modelQ.pop_front());
            if (doPush) modelQ.push_back('{addr: in_addr, data: in_data});
        end
    end

    function automatic logic [DATA_W:0] modelLookup(input logic [ADDR_W-1:0] a);
        if (rst || a == 0) return '0;
        for (int i = modelQ.size() - 1; i >= 0; i--) begin
            if (modelQ[i].addr == a) return {1'b1, modelQ[i].data};
        end
        return '0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (modelValid) begin
            logic              expReady;
            logic              expWe;
            logic [ADDR_W-1:0] expAddr;
            logic [DATA_W-1:0] expData;
            logic [DATA_W:0]   l1;
            logic [DATA_W:0]   l2;
            expReady = !rst && (modelQ.size() < DEPTH);
            expWe    = !rst && (modelQ.size() > 0) && !hold;
            expAddr  = expWe ? modelQ[0].addr : '0;
            expData  = expWe ? modelQ[0].data : '0;
            l1 = modelLookup(lookup_addr1);
            l2 = modelLookup(lookup_addr2);
            checkOutput("model.in_ready", 32'(in_ready), 32'(expReady));
            checkOutput("model.write_enable", 32'(write_enable), 32'(expWe));
            checkOutput("model.write_addr", 32'(write_addr), 32'(expAddr));
            checkOutput("model.write_data", write_data, expData);
            checkOutput("model.lookup_hit1", 32'(lookup_hit1), 32'(l1[DATA_W]));
            checkOutput("model.lookup_data1", lookup_data1, l1[DATA_W-1:0]);
            checkOutput("model.lookup_hit2", 32'(lookup_hit2), 32'(l2[DATA_W]));
            checkOutput("model.lookup_data2", lookup_data2, l2[DATA_W-1:0]);
            if (!rst) checkOutput("model.count", 32'(count), 32'(modelQ.size()));
        end
    end

    task automatic applyStimulus(input logic v, input logic we,
                                 input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d, input logic h);
        in_valid = v;
        in_we    = we;
        in_addr  = a;
        in_data  = d;
        hold     = h;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        lookup_addr1 = '0;
        lookup_addr2 = '0;
        applyStimulus(0, 0, 0, 0, 0);

        // Reset held for two cycles
        nextCycle();
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset.count", 32'(count), 0);
        checkOutput("reset.in_ready", 32'(in_ready), 1);
        checkOutput("reset.write_enable", 32'(write_enable), 0);

        // Single write: accepted at one edge, on the write port the next cycle
        applyStimulus(1, 1, 5, 32'hDEADBEEF, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("single.write_enable", 32'(write_enable), 1);
        checkOutput("single.write_addr", 32'(write_addr), 5);
        checkOutput("single.write_data", write_data, 32'hDEADBEEF);
        nextCycle();
        @(negedge clk);
        checkOutput("single.count_after", 32'(count), 0);

        // Filtered results are consumed but never written
        applyStimulus(1, 0, 7, 32'h77, 0);
        @(negedge clk);
        checkOutput("filter.ready_we0", 32'(in_ready), 1);
        nextCycle();
        applyStimulus(1, 1, 0, 32'h99, 0);
        @(negedge clk);
        checkOutput("filter.ready_x0", 32'(in_ready), 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("filter.count", 32'(count), 0);
        checkOutput("filter.write_enable", 32'(write_enable), 0);

        // Fill under hold, then drain in order; then two rounds of three to wrap
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 1, ADDR_W'(i), DATA_W'(i * 32'h11), 1);
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 1);
        lookup_addr1 = 3;
        @(negedge clk);
        checkOutput("full.count", 32'(count), 4);
        checkOutput("full.in_ready", 32'(in_ready), 0);
        checkOutput("full.write_enable_held", 32'(write_enable), 0);
        checkOutput("full.lookup_data1", lookup_data1, 32'h33);
        lookup_addr1 = 0;
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checkOutput("drain.write_addr", 32'(write_addr), i);
            checkOutput("drain.write_data", write_data, i * 32'h11);
            checkOutput("drain.in_ready", 32'(in_ready), (i == 1) ? 0 : 1);
            nextCycle();
        end
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < 3; i++) begin
                applyStimulus(1, 1, ADDR_W'(20 + 3 * round + i), DATA_W'(32'hC0 + 3 * round + i), 1);
                nextCycle();
            end
            applyStimulus(0, 0, 0, 0, 0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checkOutput("wrap.write_addr", 32'(write_addr), 20 + 3 * round + i);
                nextCycle();
            end
        end

        // Lookup priority: youngest duplicate wins, x0 never hits
        applyStimulus(1, 1, 9, 32'hA, 1);
        nextCycle();
        applyStimulus(1, 1, 9, 32'hB, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1);
        lookup_addr1 = 9;
        lookup_addr2 = 0;
        @(negedge clk);
        checkOutput("lookup.hit1", 32'(lookup_hit1), 1);
        checkOutput("lookup.data1", lookup_data1, 32'hB);
        checkOutput("lookup.hit2", 32'(lookup_hit2), 0);
        checkOutput("lookup.data2", lookup_data2, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("dup.first_data", write_data, 32'hA);
        checkOutput("dup.lookup_head_visible", lookup_data1, 32'hB);
        nextCycle();
        @(negedge clk);
        checkOutput("dup.second_data", write_data, 32'hB);
        nextCycle();
        lookup_addr1 = 0;

        // Reset while an entry is presentable: no write in that cycle
        applyStimulus(1, 1, 12, 32'h1234, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset.write_enable", 32'(write_enable), 0);
        checkOutput("midreset.in_ready", 32'(in_ready), 0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset.count", 32'(count), 0);
        checkOutput("midreset.write_enable_after", 32'(write_enable), 0);

        // Back-to-back stream: count settles at 1, one-cycle latency
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, ADDR_W'(10 + i), DATA_W'(i * 32'h101), 0);
            if (i > 0) begin
                @(negedge clk);
                checkOutput("stream.count", 32'(count), 1);
                checkOutput("stream.write_addr", 32'(write_addr), 10 + i - 1);
            end
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("stream.last_addr", 32'(write_addr), 17);
        checkOutput("stream.last_data", write_data, 7 * 32'h101);
        nextCycle();
        @(negedge clk);
        checkOutput("stream.empty", 32'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
